// File: rtl/xadc_scan_ctrl.sv
// Periodic XADC VAUX scanner: DRP-reads each enabled channel, keeps the latest 12-bit sample per channel.
// Latency: tick/start -> den in 2 cycles; no backpressure beyond the DRP drdy handshake, bounded by TIMEOUT.
module xadc_scan_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        den,
    output logic        dwe,
    output logic [6:0]  daddr,
    output logic [15:0] di,
    input  logic [15:0] drp_do,
    input  logic        drdy,
    output logic        busy
);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SEL, ISSUE, WAIT} state_t;

    state_t        state;
    logic          enable;
    logic [15:0]   mask;
    logic [31:0]   period;
    logic [31:0]   tmr;
    logic          timeout_flag;
    logic          overrun_flag;
    logic [31:0]   scan_count;
    logic [11:0]   result [16];
    logic [15:0]   valid;
    logic [15:0]   pend;
    logic [3:0]    ch;
    logic [3:0]    sel_ch;
    logic          single;
    logic          abort;
    logic [WW-1:0] wcnt;

    logic wr_en, rd_en, tick, start_req, abort_now;

    assign wr_en     = cs & write;
    assign rd_en     = cs & read;
    assign start_req = wr_en && (addr == 5'd0) && wr_data[1];
    // Terminal count at period-1; periods of 0 and 1 both tick every cycle.
    assign tick      = enable && ((period <= 32'd1) || (tmr >= period - 32'd1));
    assign abort_now = abort | (~single & ~enable);
    assign busy      = (state != IDLE);
    assign dwe       = 1'b0;
    assign di        = 16'd0;

    always_comb begin
        sel_ch = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (pend[i]) sel_ch = 4'(i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable <= 1'b0;
            mask   <= 16'd0;
            period <= 32'd0;
            tmr    <= 32'd0;
        end else begin
            if (wr_en && addr == 5'd0) enable <= wr_data[0];
            if (wr_en && addr == 5'd1) mask   <= wr_data[15:0];
            if (wr_en && addr == 5'd2) period <= wr_data;
            if (!enable || tick) tmr <= 32'd0;
            else                 tmr <= tmr + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            den          <= 1'b0;
            daddr        <= 7'd0;
            timeout_flag <= 1'b0;
            overrun_flag <= 1'b0;
            scan_count   <= 32'd0;
            valid        <= 16'd0;
            pend         <= 16'd0;
            ch           <= 4'd0;
            single       <= 1'b0;
            abort        <= 1'b0;
            wcnt         <= '0;
            for (int i = 0; i < 16; i++) result[i] <= 12'd0;
        end else begin
            den <= 1'b0;
            // Read-clear comes first so a same-cycle sample update keeps valid set.
            if (rd_en && addr[4]) valid[addr[3:0]] <= 1'b0;
            if (wr_en && addr == 5'd3) begin
                timeout_flag <= 1'b0;
                overrun_flag <= 1'b0;
            end
            if (tick && state != IDLE) overrun_flag <= 1'b1;
            if (state != IDLE && !single && !enable) abort <= 1'b1;

            case (state)
                IDLE: begin
                    if (start_req || tick) begin
                        state  <= SEL;
                        pend   <= mask;
                        single <= start_req;
                        abort  <= 1'b0;
                    end
                end
                SEL: begin
                    if (pend == 16'd0 || abort_now) begin
                        if (!abort_now) scan_count <= scan_count + 32'd1;
                        state <= IDLE;
                    end else begin
                        ch           <= sel_ch;
                        pend[sel_ch] <= 1'b0;
                        daddr        <= 7'h10 + {3'b000, sel_ch};
                        den          <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    wcnt  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (drdy) begin
                        result[ch] <= drp_do[15:4];
                        valid[ch]  <= 1'b1;
                        state      <= SEL;
                    end else if (wcnt == WW'(TIMEOUT - 1)) begin
                        timeout_flag <= 1'b1;
                        state        <= SEL;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rd_data = 32'd0;
        case (addr)
            5'd0: rd_data = {31'd0, enable};
            5'd1: rd_data = {16'd0, mask};
            5'd2: rd_data = period;
            5'd3: rd_data = {29'd0, overrun_flag, timeout_flag, busy};
            5'd4: rd_data = scan_count;
            default: begin
                if (addr[4]) rd_data = {15'd0, valid[addr[3:0]], 4'd0, result[addr[3:0]]};
            end
        endcase
    end
endmodule
